// File: rtl/demo_pkg.sv
// demo_pkg: shared state encoding and default widths for the demo pattern generator
package demo_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;
   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int GAP_W = 4;
   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      SEND = ST_SEND,
      GAP  = ST_GAP,
      DONE = ST_DONE
   } state_t;
endpackage

// File: rtl/demo_down_cnt.sv
// demo_down_cnt: loadable down-counter with zero flag, holds at zero
module demo_down_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] din,
   output logic         zero
);
   logic [W-1:0] cnt_q;
   // load takes priority; decrement saturates at zero
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else if (load) cnt_q <= din;
      else if (dec && cnt_q != '0) cnt_q <= cnt_q - W'(1);
   assign zero = cnt_q == '0;
endmodule

// File: rtl/demo_seq_gen.sv
// demo_seq_gen: framed serial pattern transmitter with repetitions and idle gaps
module demo_seq_gen #(
   parameter int PAT_W = demo_pkg::PAT_W,
   parameter int CNT_W = demo_pkg::CNT_W,
   parameter int GAP_W = demo_pkg::GAP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done
);
   import demo_pkg::*;
   localparam int IDX_W = $clog2(PAT_W);
   state_t           state_q;
   logic [PAT_W-1:0] pat_q, shreg_q;
   logic [GAP_W-1:0] gap_q;
   logic [IDX_W-1:0] bidx_q;
   logic             bit_out_q, bit_valid_q, busy_q, done_q;
   logic             accept, last_bit, rep_zero, gap_zero;
   logic             rep_load, rep_dec, gap_load, gap_dec;
   logic [CNT_W-1:0] rep_din;
   logic [GAP_W-1:0] gap_din;
   // rep counter holds repetitions remaining after the current one; gap counter holds gap cycles left minus one
   always_comb begin
      accept   = (state_q == IDLE || state_q == DONE) && start;
      last_bit = state_q == SEND && bidx_q == '0;
      rep_load = accept;
      rep_din  = repeat_n == '0 ? '0 : repeat_n - CNT_W'(1);
      rep_dec  = last_bit && !rep_zero;
      gap_load = last_bit && !rep_zero && gap_q != '0;
      gap_din  = gap_q - GAP_W'(1);
      gap_dec  = state_q == GAP && !gap_zero;
   end
   demo_down_cnt #(.W(CNT_W)) u_rep (
      .clk(clk), .rst(rst), .load(rep_load), .dec(rep_dec), .din(rep_din), .zero(rep_zero)
   );
   demo_down_cnt #(.W(GAP_W)) u_gap (
      .clk(clk), .rst(rst), .load(gap_load), .dec(gap_dec), .din(gap_din), .zero(gap_zero)
   );
   // FSM with registered outputs: each edge decides next state and the outputs for the coming cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pat_q       <= '0;
         shreg_q     <= '0;
         gap_q       <= '0;
         bidx_q      <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               bit_out_q   <= 1'b0;
               bit_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
               if (start) begin
                  pat_q <= pattern;
                  gap_q <= gap;
                  if (repeat_n == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= SEND;
                     bit_out_q   <= pattern[PAT_W-1];
                     bit_valid_q <= 1'b1;
                     busy_q      <= 1'b1;
                     shreg_q     <= pattern << 1;
                     bidx_q      <= IDX_W'(PAT_W-1);
                  end
               end
            end
            SEND: begin
               if (bidx_q != '0) begin
                  bit_out_q <= shreg_q[PAT_W-1];
                  shreg_q   <= shreg_q << 1;
                  bidx_q    <= bidx_q - IDX_W'(1);
               end else if (rep_zero) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  bit_valid_q <= 1'b0;
                  bit_out_q   <= 1'b0;
               end else if (gap_q != '0) begin
                  state_q     <= GAP;
                  bit_valid_q <= 1'b0;
                  bit_out_q   <= 1'b0;
               end else begin
                  bit_out_q <= pat_q[PAT_W-1];
                  shreg_q   <= pat_q << 1;
                  bidx_q    <= IDX_W'(PAT_W-1);
               end
            end
            GAP: begin
               if (gap_zero) begin
                  state_q     <= SEND;
                  bit_out_q   <= pat_q[PAT_W-1];
                  bit_valid_q <= 1'b1;
                  shreg_q     <= pat_q << 1;
                  bidx_q      <= IDX_W'(PAT_W-1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_demo_seq_gen.sv
// tb_demo_seq_gen: scoreboard bench for the serial pattern transmitter
module tb_demo_seq_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] pattern = '0;
   logic [7:0] repeat_n = '0;
   logic [3:0] gap = '0;
   logic       bit_out, bit_valid, busy, done;
   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   demo_seq_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
      .gap(gap), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // expected per-cycle {bit_valid, bit_out, busy, done} starting the cycle after the accepting edge
   task automatic push_expected(input logic [3:0] pat, input int r, input int g);
      for (int i = 0; i < r; i++) begin
         for (int b = 3; b >= 0; b--) exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
         if (i < r - 1) for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0000);
   endtask

   task automatic send(input logic [3:0] pat, input int r, input int g, input string name, input int poke);
      logic [3:0] obs, exp;
      int k = 0;
      @(negedge clk);
      pattern = pat; repeat_n = 8'(r); gap = 4'(g); start = 1'b1;
      push_expected(pat, r, g);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         start = (k == poke);
         pattern = (k == poke) ? 4'b0000 : ~pat;
         repeat_n = 8'd5;
         gap = 4'd1;
         obs = {bit_valid, bit_out, busy, done};
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: {valid,bit,busy,done} got %b expected %b", name, k + 1, obs, exp);
         end
         k++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 checks++;
      if ({bit_valid, bit_out, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held: got %b expected 0000", {bit_valid, bit_out, busy, done});
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1 checks++;
      if ({bit_valid, bit_out, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release: got %b expected 0000", {bit_valid, bit_out, busy, done});
      end
   endtask

   task automatic test_single();       send(4'b1011, 1, 0, "single", -1); endtask
   task automatic test_gap();          send(4'b1001, 3, 2, "gap", -1);    endtask
   task automatic test_back_to_back(); send(4'b1100, 2, 0, "b2b", -1);    endtask
   task automatic test_zero();         send(4'b1111, 0, 3, "zero_rep", -1); endtask
   task automatic test_ignore_start(); send(4'b1011, 1, 0, "ignore_start", 1); endtask
   task automatic test_max_gap();      send(4'b0101, 2, 15, "max_gap", -1); endtask

   task automatic test_async_reset();
      @(negedge clk);
      pattern = 4'b1011; repeat_n = 8'd1; gap = 4'd0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 checks++;
      if ({bit_valid, bit_out, busy, done} !== 4'b1010) begin
         errors++;
         $display("FAIL pre_async_rst: got %b expected 1010", {bit_valid, bit_out, busy, done});
      end
      #2 rst = 1'b1;
      #1 checks++;
      if ({bit_valid, bit_out, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL async_rst: got %b expected 0000", {bit_valid, bit_out, busy, done});
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1 checks++;
      if ({bit_valid, bit_out, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL post_async_rst_idle: got %b expected 0000", {bit_valid, bit_out, busy, done});
      end
      send(4'b0110, 1, 0, "post_rst", -1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_gap();
      test_back_to_back();
      test_zero();
      test_ignore_start();
      test_max_gap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/demo_seq_gen.md
Name: demo_seq_gen

Overview:
- Serial pattern transmitter feeding the 1-bit input of the `demo` serial detector, replacing free-running `$random` stimulus with deterministic framed bit streams.
- Latches a PAT_W-bit pattern, shifts it out MSB-first for a programmable number of repetitions, with an optional idle gap between repetitions.
- Reports `busy` while sending and pulses `done` when finished.
- Sits beside `demo` in the test harness and in any top level that drives the detector.

Parameters:
- PAT_W, 4: pattern width in bits (>=2).
- CNT_W, 8: width of the repetition count.
- GAP_W, 4: width of the inter-repetition gap count, in clock cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a transfer; sampled on a clk rising edge.
- pattern  input  PAT_W  bit pattern, sent MSB first.
- repeat_n  input  CNT_W  number of pattern repetitions.
- gap  input  GAP_W  idle cycles inserted between repetitions.
- bit_out  output  1  serial data; connects to `demo.a`.
- bit_valid  output  1  bit_out carries a pattern bit this cycle.
- busy  output  1  transfer in progress; start is ignored while high.
- done  output  1  single-cycle completion pulse.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset, asserted at any time including mid-transfer:
  - state goes to IDLE;
  - bit_out, bit_valid, busy and done all go to 0;
  - latched pattern, counters and shift register clear.
- All outputs are registered.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - bit_valid=0 and bit_out=0.
  - When start=1 at an edge, latch pattern, repeat_n and gap, and set busy=1 after that edge.
  - If latched repeat_n=0, go to DONE. Otherwise go to SEND.
- SEND:
  - In the first cycle after the accepting edge, bit_out=pattern[PAT_W-1] and bit_valid=1.
  - Each following cycle shifts one bit toward the LSB, for exactly PAT_W consecutive valid cycles per repetition.
  - After the LSB cycle, with repetitions remaining:
    - if gap>0, go to GAP;
    - if gap=0, go directly to SEND with the MSB in the very next cycle (back-to-back).
  - After the LSB cycle of the last repetition, go to DONE.
- GAP:
  - Lasts exactly `gap` cycles with bit_valid=0 and bit_out=0, then returns to SEND.
  - No gap is inserted after the final repetition.
- DONE:
  - done=1 for exactly one cycle and busy=0 in that same cycle.
  - Then return to IDLE. A new start may be accepted on the edge that ends the DONE cycle.
- Timing, with R=repeat_n>0 and G=gap:
  - busy is high for PAT_W*R + G*(R-1) cycles.
  - done follows in the next cycle.
  - For R=0: one DONE cycle immediately after the accepting edge, busy never asserted, no valid bits.
- Start while busy or in DONE is ignored; no queuing.
- Input changes after acceptance have no effect.
- Counters:
  - Repetition counter is CNT_W wide and counts down to 1; no wrap, so repeat_n = 2^CNT_W-1 is supported.
  - Gap counter is GAP_W wide.
  - Bit index is $clog2(PAT_W) wide.
- bit_out is 0 whenever bit_valid=0.

Decomposition:
- Shared package demo_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_SEND=2'd1, ST_GAP=2'd2, ST_DONE=2'd3;
  - default widths PAT_W/CNT_W/GAP_W.
- One natural sub-module: demo_down_cnt, a loadable down-counter with a zero flag and async reset. It is instantiated twice, for repetitions and for gap.
- The shift register and FSM stay in the top module.

Test Plan:
- pattern=4'b1011, repeat_n=1, gap=0, start pulse at edge t0 -> bit_out = 1,0,1,1 with bit_valid=1 in cycles t0+1..t0+4; done=1 in cycle t0+5; busy high in cycles t0+1..t0+4.
- pattern=4'b1001, repeat_n=3, gap=2 -> valid bits 1001, 2 idle cycles (bit_out=0), 1001, 2 idle, 1001; busy high 16 cycles; done pulse in cycle 17; `demo` output matches its detection of that stream.
- pattern=4'b1100, repeat_n=2, gap=0 -> 8 contiguous valid cycles 11001100; done in the 9th cycle.
- repeat_n=0, start=1 -> bit_valid never 1, busy stays 0, done=1 in the cycle right after the edge.
- start re-asserted with pattern=4'b0000 during the 2nd bit of a 4'b1011 transfer -> stream continues 1,1 unchanged, exactly one done.
- rst asserted asynchronously mid-SEND, between edges -> bit_out, bit_valid, busy and done go to 0 immediately without waiting for a clk edge. After rst deasserts, start with pattern=4'b0110, repeat_n=1 -> clean 0,1,1,0 stream.
